serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial N-bit subtractor: the inverse of the adder datapath. It accepts two operands and a borrow-in over a valid/ready handshake, then computes D = A − B − Bin one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It presents the difference and the borrow-out over a second valid/ready handshake. It sits alongside the adder blocks as the area-minimal arithmetic option for paths that can tolerate multi-cycle latency.

## Interface
- Parameter `WIDTH`, default 8: operand and result width in bits. Legal range is ≥ 2.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`, input, 1: clock. All state updates on its rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start_valid`, input, 1: operands valid.
- `start_ready`, output, 1: block idle and able to accept operands.
- `A`, input, WIDTH: minuend. Sampled only on the start handshake.
- `B`, input, WIDTH: subtrahend. Sampled only on the start handshake.
- `Bin`, input, 1: borrow-in. Sampled only on the start handshake.
- `D`, output, WIDTH: difference, valid while `done_valid` is high.
- `Bout`, output, 1: borrow-out, i.e. the unsigned underflow of A − B − Bin.
- `done_valid`, output, 1: result available.
- `done_ready`, input, 1: consumer accepts the result.
- `V`, output, 1: signed overflow. Present only with `SERIAL_SUB_OVF_EN`.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- IDLE
  - `start_ready` = 1.
  - On `start_valid && start_ready`: load A and B into shift registers, load the borrow FF from `Bin`, clear the bit counter, and go to SHIFT.
- SHIFT
  - Each cycle, take a = A_sr[0], b = B_sr[0] and br = the borrow FF.
  - Difference bit: d = a ^ b ^ br.
  - Next borrow: br' = (~a & b) | (~(a ^ b) & br).
  - d shifts into the MSB of the D register (right shift). A_sr and B_sr shift right. The counter increments.
  - When the counter reaches WIDTH−1, the same edge completes the last bit and moves the FSM to DONE.
- DONE
  - `done_valid` = 1.
  - `D` equals (A − B − Bin) mod 2^WIDTH.
  - `Bout` is the final borrow.
  - On `done_valid && done_ready`, go to IDLE.
- Outputs `D`, `Bout` and `V` are held stable from DONE entry until the next start handshake. They are not cleared on return to IDLE.
- `start_valid` in SHIFT or DONE is ignored; `start_ready` is 0 there.
- The counter width is max(1, $clog2(WIDTH)). The counter never wraps within an operation.

## Timing
- Reset values: state is IDLE; `start_ready` = 1, `done_valid` = 0, `D` = 0, `Bout` = 0, `V` = 0. The shift registers, counter and borrow FF are all 0.
- Latency: a start handshake at edge 0 means `done_valid` is asserted after edge WIDTH.
- Throughput: one operation per WIDTH+2 cycles at best. There is one IDLE cycle between operations.
- If `done_ready` is high at DONE entry, the result is consumed on the first DONE cycle. If `done_ready` is low, the block holds DONE indefinitely and all outputs remain stable.
- Reset asserted mid-SHIFT or mid-DONE aborts the operation immediately. All outputs take their reset values and no partial result is presented.
- There is no combinational path from `done_ready` to `start_ready` or from `start_valid` to any output.

## Configuration
- `SERIAL_SUB_OVF_EN` defined: adds output `V` as the two's-complement overflow.
  - V = (A[MSB] ^ B[MSB]) & (A[MSB] ^ D[MSB]), evaluated on the operands captured at start.
  - Registered on the DONE-entry edge, held like `D`, and reset to 0.
- `SERIAL_SUB_OVF_EN` undefined: the port `V` and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=8, A=0x05, B=0x03, Bin=0 → D=0x02, Bout=0. `done_valid` rises exactly 8 edges after the start handshake.
- A=0x03, B=0x05, Bin=0 → D=0xFE, Bout=1.
- A=0x00, B=0x00, Bin=1 → D=0xFF, Bout=1.
- Backpressure:
  - Hold `done_ready`=0 for 5 cycles in DONE → D, Bout and `done_valid` stay stable and `start_ready`=0.
  - Raise `done_ready` → the block returns to IDLE on the next edge.
  - Pulse `start_valid` mid-SHIFT → no effect on the result.
- Reset during SHIFT: deassert `rst_n` at cycle 3 of A=0xAA, B=0x55 → all outputs read 0 immediately and `start_ready`=1 after release. A following operation with A=0x10, B=0x01 gives D=0x0F.
- With `SERIAL_SUB_OVF_EN`:
  - A=0x80, B=0x01, Bin=0 → D=0x7F, V=1, Bout=0.
  - A=0x7F, B=0x01 → D=0x7E, V=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial N-bit subtractor, D = A - B - Bin, LSB first (optional V via SERIAL_SUB_OVF_EN)
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             done_valid,
   input  logic             done_ready
`ifdef SERIAL_SUB_OVF_EN
   ,output logic            V
`endif
);

   localparam int CW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_d;
   logic [CW-1:0]    r_cnt;
   logic             r_br;
   logic             r_bout;
   logic             r_start_ready;
   logic             r_done_valid;

   logic w_a;
   logic w_b;
   logic w_d;
   logic w_br_next;
   logic w_last;

   // full-subtractor cell on the current LSBs and the borrow FF
   assign w_a       = r_a_sr[0];
   assign w_b       = r_b_sr[0];
   assign w_d       = w_a ^ w_b ^ r_br;
   assign w_br_next = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
   assign w_last    = (r_cnt == LAST);

`ifdef SERIAL_SUB_OVF_EN
   logic r_v;
   logic w_v;
   // on the last bit the shift registers expose the operand MSBs and w_d is the result MSB
   assign w_v = (w_a ^ w_b) & (w_a ^ w_d);
   assign V   = r_v;
`endif

   assign start_ready = r_start_ready;
   assign done_valid  = r_done_valid;
   assign D           = r_d;
   assign Bout        = r_bout;

   // control FSM and datapath; handshake outputs are registered alongside the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_a_sr        <= '0;
         r_b_sr        <= '0;
         r_d           <= '0;
         r_cnt         <= '0;
         r_br          <= 1'b0;
         r_bout        <= 1'b0;
         r_start_ready <= 1'b1;
         r_done_valid  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         r_v           <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_valid && r_start_ready) begin
                  r_a_sr        <= A;
                  r_b_sr        <= B;
                  r_br          <= Bin;
                  r_cnt         <= '0;
                  r_start_ready <= 1'b0;
                  r_state       <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
               r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
               r_d    <= {w_d, r_d[WIDTH-1:1]};
               r_br   <= w_br_next;
               if (w_last) begin
                  r_bout       <= w_br_next;
                  r_done_valid <= 1'b1;
                  r_state      <= S_DONE;
`ifdef SERIAL_SUB_OVF_EN
                  r_v          <= w_v;
`endif
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (done_ready) begin
                  r_done_valid  <= 1'b0;
                  r_start_ready <= 1'b1;
                  r_state       <= S_IDLE;
               end
            end
            default: begin
               r_state       <= S_IDLE;
               r_start_ready <= 1'b1;
               r_done_valid  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start_valid;
   logic         start_ready;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Bin;
   logic [W-1:0] D;
   logic         Bout;
   logic         done_valid;
   logic         done_ready;
`ifdef SERIAL_SUB_OVF_EN
   logic         V;
`endif

   serial_subtractor #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .A           (A),
      .B           (B),
      .Bin         (Bin),
      .D           (D),
      .Bout        (Bout),
      .done_valid  (done_valid),
      .done_ready  (done_ready)
`ifdef SERIAL_SUB_OVF_EN
      ,.V          (V)
`endif
   );

   typedef struct packed {
      logic [W-1:0] d;
      logic         bout;
      logic         v;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // monitor: pop the scoreboard whenever a result handshake happens
   always @(negedge clk) begin
      if (rst_n && done_valid && done_ready) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual D=%0h expected no result", D);
         end else begin
            mon_e = q.pop_front();
            chk("result_D", {24'd0, D}, {24'd0, mon_e.d});
            chk("result_Bout", {31'd0, Bout}, {31'd0, mon_e.bout});
`ifdef SERIAL_SUB_OVF_EN
            chk("result_V", {31'd0, V}, {31'd0, mon_e.v});
`endif
         end
      end
   end

   task automatic wait_ready();
      int t = 0;
      while (!start_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (!start_ready) chk("start_ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input logic [W-1:0] ed, input logic eb, input logic ev,
                         input int hold, input bit pulse);
      int n;
      wait_ready();
      q.push_back('{d: ed, bout: eb, v: ev});
      A = a; B = b; Bin = bin;
      done_ready  = (hold == 0);
      start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      n = 0;
      while (!done_valid && n < 40) begin
         if (pulse) begin
            start_valid = (n == 3);
            if (n == 3) begin
               A = 8'hFF; B = 8'h00; Bin = 1'b1;
            end
         end
         @(posedge clk); #1;
         n++;
      end
      start_valid = 1'b0;
      chk("latency", n, W);
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_done_valid", {31'd0, done_valid}, 32'd1);
            chk("hold_start_ready", {31'd0, start_ready}, 32'd0);
            chk("hold_D", {24'd0, D}, {24'd0, ed});
            chk("hold_Bout", {31'd0, Bout}, {31'd0, eb});
         end
         @(posedge clk); #1;
         done_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk("idle_done_valid", {31'd0, done_valid}, 32'd0);
      chk("idle_start_ready", {31'd0, start_ready}, 32'd1);
      chk("idle_D_held", {24'd0, D}, {24'd0, ed});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start_valid = 1'b0; A = '0; B = '0; Bin = 1'b0; done_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
      chk("rst_done_valid", {31'd0, done_valid}, 32'd0);
      chk("rst_D", {24'd0, D}, 32'd0);
      chk("rst_Bout", {31'd0, Bout}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0, 1'b0);
      run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 5, 1'b1);
      run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
      run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0, 1'b0);
      run_op(8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0, 0, 1'b0);
      run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
      run_op(8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1, 2, 1'b0);

      // reset during SHIFT: nothing is pushed, no result may appear
      wait_ready();
      A = 8'hAA; B = 8'h55; Bin = 1'b0; done_ready = 1'b1;
      start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_D", {24'd0, D}, 32'd0);
      chk("abort_Bout", {31'd0, Bout}, 32'd0);
      chk("abort_done_valid", {31'd0, done_valid}, 32'd0);
      chk("abort_start_ready", {31'd0, start_ready}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_abort_start_ready", {31'd0, start_ready}, 32'd1);
      chk("post_abort_done_valid", {31'd0, done_valid}, 32'd0);

      run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 0, 1'b0);

      repeat (4) @(posedge clk);
      chk("scoreboard_empty", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
